// File: rtl/i2c_master_pkg.sv
// Shared types and constants for the single-slave I2C master.
package i2c_master_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ACK1,
    WDATA,
    ACK2,
    RSTART,
    ADDR_R,
    ACK3,
    RDATA,
    MNACK,
    STOP
  } i2c_state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } q_phase_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Address byte as it appears on the wire: 7-bit address then R/W.
  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rw);
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-phase timebase: one tick every 2*DIV_FACTOR clk cycles while enabled,
// with a Q0..Q3 index that advances on each tick.
module i2c_clk_gen
  import i2c_master_pkg::*;
#(
  parameter int unsigned DIV_FACTOR = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     enable,
  input  logic     clear,
  output logic     tick,
  output q_phase_t phase
);

  localparam int unsigned CNT_MAX = 2 * DIV_FACTOR - 1;
  localparam int unsigned CW      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == CW'(CNT_MAX));

  // Divider counter and quarter-phase index; clear realigns both to a fresh bit.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (enable) begin
      if (tick) begin
        cnt   <= '0;
        phase <= q_phase_t'(phase + 2'd1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C controller: one start runs either a one-byte write or a
// register-pointer write followed by a repeated-START one-byte read.
module i2c_master
  import i2c_master_pkg::*;
#(
  parameter int unsigned DIV_FACTOR    = 16,
  parameter logic [6:0]  SLAVE_ADDRESS = 7'h68
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       start,
  input  logic       stop,
  inout  wire        SDA_BUS,
  output logic       SCL_BUS,
  output logic [7:0] data_out,
  output logic       avail_data_out,
  output logic       avail_i2c_master
);

  i2c_state_t state, state_n;
  q_phase_t   phase;
  logic       tick;
  logic       accept;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] data_reg, data_reg_n;
  logic       mode_reg, mode_n;
  logic       sda_low, sda_low_n;
  logic       scl, scl_n;
  logic       nack, nack_n;
  logic [7:0] data_out_n;
  logic       avail_data_out_n;
  logic       sda_in;

  // Released SDA reads high through the board pull-up.
  assign SDA_BUS          = sda_low ? 1'b0 : 1'bz;
  assign sda_in           = SDA_BUS;
  assign SCL_BUS          = scl;
  assign avail_i2c_master = (state == IDLE);

  i2c_clk_gen #(
    .DIV_FACTOR(DIV_FACTOR)
  ) u_clk_gen (
    .clk   (clk),
    .reset (reset),
    .enable(state != IDLE),
    .clear (accept),
    .tick  (tick),
    .phase (phase)
  );

  // State and datapath registers; reset releases the bus without a STOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      bit_cnt        <= '0;
      shift          <= '0;
      data_reg       <= '0;
      mode_reg       <= 1'b0;
      sda_low        <= 1'b0;
      scl            <= 1'b1;
      nack           <= 1'b0;
      data_out       <= '0;
      avail_data_out <= 1'b0;
    end else begin
      state          <= state_n;
      bit_cnt        <= bit_cnt_n;
      shift          <= shift_n;
      data_reg       <= data_reg_n;
      mode_reg       <= mode_n;
      sda_low        <= sda_low_n;
      scl            <= scl_n;
      nack           <= nack_n;
      data_out       <= data_out_n;
      avail_data_out <= avail_data_out_n;
    end
  end

  // Next-state and bus levels. Every state spans one full Q0..Q3 bit slot;
  // the bus values are set on the tick that enters each quarter, and state
  // changes happen on the tick leaving Q3, so SDA and SCL never move together.
  always_comb begin
    state_n          = state;
    bit_cnt_n        = bit_cnt;
    shift_n          = shift;
    data_reg_n       = data_reg;
    mode_n           = mode_reg;
    sda_low_n        = sda_low;
    scl_n            = scl;
    nack_n           = nack;
    data_out_n       = data_out;
    avail_data_out_n = 1'b0;
    accept           = 1'b0;

    if (state == IDLE) begin
      scl_n     = 1'b1;
      sda_low_n = 1'b0;
      if (start) begin
        accept     = 1'b1;
        data_reg_n = data_in;
        mode_n     = stop;
        state_n    = START;
      end
    end else if (tick) begin
      unique case (phase)
        Q0: begin
          // entering Q1: SDA update point
          unique case (state)
            START, STOP:         sda_low_n = 1'b1;
            ADDR, WDATA, ADDR_R: sda_low_n = ~shift[7];
            default:             sda_low_n = 1'b0;
          endcase
        end
        Q1: begin
          // entering Q2: SCL rises, except START which drops SCL here
          scl_n = (state != START);
        end
        Q2: begin
          // entering Q3: sample point, plus the SDA edges of RSTART/STOP
          unique case (state)
            RSTART:           sda_low_n = 1'b1;
            STOP:             sda_low_n = 1'b0;
            ACK1, ACK2, ACK3: nack_n = sda_in;
            RDATA:            shift_n = {shift[6:0], sda_in};
            default:          ;
          endcase
        end
        Q3: begin
          // leaving the slot: SCL falls and the next state begins
          scl_n = 1'b0;
          unique case (state)
            START: begin
              state_n   = ADDR;
              shift_n   = addr_byte(SLAVE_ADDRESS, RW_WRITE);
              bit_cnt_n = 3'd7;
            end
            ADDR, WDATA, ADDR_R: begin
              if (bit_cnt == 3'd0) begin
                state_n = (state == ADDR) ? ACK1 : ((state == WDATA) ? ACK2 : ACK3);
              end else begin
                bit_cnt_n = bit_cnt - 3'd1;
                shift_n   = {shift[6:0], 1'b0};
              end
            end
            ACK1: begin
              if (nack) begin
                state_n = STOP;
              end else begin
                state_n   = WDATA;
                shift_n   = data_reg;
                bit_cnt_n = 3'd7;
              end
            end
            ACK2: state_n = (nack || mode_reg) ? STOP : RSTART;
            RSTART: begin
              state_n   = ADDR_R;
              shift_n   = addr_byte(SLAVE_ADDRESS, RW_READ);
              bit_cnt_n = 3'd7;
            end
            ACK3: begin
              if (nack) begin
                state_n = STOP;
              end else begin
                state_n   = RDATA;
                bit_cnt_n = 3'd7;
              end
            end
            RDATA: begin
              if (bit_cnt == 3'd0) state_n = MNACK;
              else                 bit_cnt_n = bit_cnt - 3'd1;
            end
            MNACK: begin
              state_n          = STOP;
              data_out_n       = shift;
              avail_data_out_n = 1'b1;
            end
            STOP: begin
              state_n = IDLE;
              scl_n   = 1'b1;
            end
            default: state_n = IDLE;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: a bus-level slave/monitor decodes
// START/STOP/bytes from the wires and is compared against an expected
// transaction log built from the protocol rules.
module tb_i2c_master;

  localparam int unsigned DIV   = 16;
  localparam logic [6:0]  SLAVE = 7'h68;
  localparam int unsigned EV_START = 32'h1000;
  localparam int unsigned EV_STOP  = 32'h2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       scl_bus;
  logic [7:0] data_out;
  logic       avail_data_out;
  logic       avail_i2c_master;
  wire        sda_bus;

  logic slave_low = 1'b0;
  pullup (sda_bus);
  assign sda_bus = slave_low ? 1'b0 : 1'bz;

  i2c_master #(
    .DIV_FACTOR   (DIV),
    .SLAVE_ADDRESS(SLAVE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .start           (start),
    .stop            (stop),
    .SDA_BUS         (sda_bus),
    .SCL_BUS         (scl_bus),
    .data_out        (data_out),
    .avail_data_out  (avail_data_out),
    .avail_i2c_master(avail_i2c_master)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave behaviour and bus monitor state
  int unsigned cyc = 0;
  int unsigned last_rise = 0;
  int unsigned ev_q[$];
  int unsigned exp_q[$];
  logic        mon_en = 1'b0;
  logic        scl_prev = 1'b1;
  logic        sda_prev = 1'b1;
  logic        scl_now;
  logic        sda_now;
  logic [8:0]  bitbuf = '0;
  int unsigned bitcnt = 0;
  logic        first_byte = 1'b0;
  logic        rd_mode = 1'b0;
  logic        slave_present = 1'b1;
  logic [7:0]  slave_rd = '0;
  int unsigned pulse_cnt = 0;
  logic [7:0]  pulse_data = '0;

  always @(posedge clk) cyc++;

  // Decode the wires once per clk and play the slave role on SCL falls.
  always @(negedge clk) begin
    scl_now = scl_bus;
    sda_now = sda_bus;
    if (avail_data_out) begin
      pulse_cnt++;
      pulse_data = data_out;
    end
    if (mon_en) begin
      if (scl_now != scl_prev || sda_now != sda_prev)
        check("scl_sda_same_clk", 32'((scl_now != scl_prev) && (sda_now != sda_prev)), 32'd0);
      if (scl_prev && scl_now && sda_prev && !sda_now) begin
        ev_q.push_back(EV_START);
        bitcnt     = 0;
        first_byte = 1'b1;
        rd_mode    = 1'b0;
      end else if (scl_prev && scl_now && !sda_prev && sda_now) begin
        ev_q.push_back(EV_STOP);
      end else if (!scl_prev && scl_now) begin
        if (bitcnt != 0) check("scl_period", cyc - last_rise, 32'(8 * DIV));
        last_rise = cyc;
        bitbuf    = {bitbuf[7:0], sda_now};
        bitcnt++;
        if (bitcnt == 9) begin
          ev_q.push_back(32'(bitbuf));
          if (first_byte) rd_mode = bitbuf[1] && !bitbuf[0];
          else            rd_mode = 1'b0;
          first_byte = 1'b0;
          bitcnt     = 0;
        end
      end else if (scl_prev && !scl_now) begin
        if (rd_mode && bitcnt < 8)       slave_low = ~slave_rd[7 - bitcnt];
        else if (!rd_mode && bitcnt == 8) slave_low = slave_present;
        else                              slave_low = 1'b0;
      end
    end
    scl_prev = scl_now;
    sda_prev = sda_now;
  end

  // Expected bus log for one transaction, from the protocol rules.
  logic [7:0]  model_data_out = '0;
  int unsigned exp_pulses = 0;

  task automatic model_txn(input logic wr_only, input logic [7:0] d, input logic present,
                           input logic [7:0] rd);
    exp_q = {};
    exp_pulses = 0;
    exp_q.push_back(EV_START);
    exp_q.push_back(32'({SLAVE, 1'b0, ~present}));
    if (present) begin
      exp_q.push_back(32'({d, 1'b0}));
      if (!wr_only) begin
        exp_q.push_back(EV_START);
        exp_q.push_back(32'({SLAVE, 1'b1, 1'b0}));
        exp_q.push_back(32'({rd, 1'b1}));
        model_data_out = rd;
        exp_pulses = 1;
      end
    end
    exp_q.push_back(EV_STOP);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20000; i++) begin
      if (avail_i2c_master) break;
      @(negedge clk);
    end
    check(tag, 32'(avail_i2c_master), 32'd1);
  endtask

  task automatic run_txn(input logic wr_only, input logic [7:0] d, input logic present,
                         input logic [7:0] rd, input logic poke_busy);
    model_txn(wr_only, d, present, rd);
    slave_present = present;
    slave_rd = rd;
    ev_q = {};
    pulse_cnt = 0;
    @(negedge clk);
    data_in = d;
    stop    = wr_only;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = 8'($urandom);
    stop    = 1'($urandom);
    check("accept_busy", 32'(avail_i2c_master), 32'd0);
    if (poke_busy) begin
      repeat (700) @(negedge clk);
      data_in = ~d;
      stop    = ~wr_only;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      check("busy_after_poke", 32'(avail_i2c_master), 32'd0);
    end
    wait_idle("idle_timeout");
    repeat (4) @(negedge clk);
    check("ev_count", 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("ev%0d", i), (i < ev_q.size()) ? ev_q[i] : 32'hFFFF_FFFF, exp_q[i]);
    check("data_out", 32'(data_out), 32'(model_data_out));
    check("pulse_cnt", pulse_cnt, exp_pulses);
    if (exp_pulses != 0) check("pulse_data", 32'(pulse_data), 32'(rd));
    check("scl_idle", 32'(scl_bus), 32'd1);
    check("sda_idle", 32'(sda_bus), 32'd1);
  endtask

  initial begin
    // Reset held for one clk
    @(negedge clk);
    check("rst_scl", 32'(scl_bus), 32'd1);
    check("rst_sda", 32'(sda_bus), 32'd1);
    check("rst_avail", 32'(avail_i2c_master), 32'd1);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_avail_data", 32'(avail_data_out), 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Directed transactions
    run_txn(1'b1, 8'h31, 1'b1, 8'h00, 1'b0);
    run_txn(1'b0, 8'h75, 1'b1, 8'hF0, 1'b0);
    run_txn(1'b1, 8'h5A, 1'b0, 8'h00, 1'b0);
    run_txn(1'b0, 8'h3B, 1'b0, 8'hA5, 1'b0);

    // Start while busy is ignored
    run_txn(1'b1, 8'($urandom), 1'b1, 8'h00, 1'b1);

    // Randomised writes and reads
    for (int k = 0; k < 2; k++) begin
      run_txn(1'b1, 8'($urandom), 1'b1, 8'h00, 1'b0);
      run_txn(1'b0, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
    end

    // Reset in the middle of WDATA (SCL low, SDA held low by the master)
    slave_present = 1'b1;
    @(negedge clk);
    data_in = 8'h00;
    stop    = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1580) @(negedge clk);
    check("mid_scl_low", 32'(scl_bus), 32'd0);
    check("mid_sda_low", 32'(sda_bus), 32'd0);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    check("mrst_scl", 32'(scl_bus), 32'd1);
    check("mrst_sda", 32'(sda_bus), 32'd1);
    check("mrst_avail", 32'(avail_i2c_master), 32'd1);
    check("mrst_data_out", 32'(data_out), 32'd0);
    reset = 1'b0;
    model_data_out = 8'h00;
    repeat (300) @(negedge clk);
    check("post_rst_scl", 32'(scl_bus), 32'd1);
    check("post_rst_avail", 32'(avail_i2c_master), 32'd1);
    mon_en = 1'b1;

    // Recovery after reset
    run_txn(1'b0, 8'($urandom), 1'b1, 8'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
